instr_reg_scheduler: RTL and testbench
======================================

# instr_reg_scheduler

Write-port arbiter and FIFO sequencer for the 32-entry instruction register. It shares the register's single write port between NUM_REQ requesters using a valid/ready handshake and a round-robin grant, and allocates write_pointer in ring order. It also walks read_pointer in the same order to present stored instruction words to one consumer, so the register operates as a 32-deep instruction queue. It sits between the instruction sources and the register instance; the top level drives the register's reset_n from !reset.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- DEPTH, 32, entries; must equal 2**$bits(address_t)
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  [NUM_REQ]  requester i has an instruction
- req_opcode  in  opcode_t [NUM_REQ]  per-requester opcode
- req_operand_a  in  operand_t [NUM_REQ]  per-requester operand A
- req_operand_b  in  operand_t [NUM_REQ]  per-requester operand B
- req_ready  out  [NUM_REQ]  one-hot grant; a transfer happens when valid && ready
- flush  in  1  synchronous queue clear
- load_en  out  1  to register load_en
- write_pointer  out  address_t  to register write_pointer
- opcode, operand_a, operand_b  out  opcode_t/operand_t  to register data inputs (granted requester's fields)
- read_pointer  out  address_t  to register read_pointer
- instruction_word  in  instruction_t  from register
- iw_valid  out  1  head entry is valid
- iw_ready  in  1  consumer accepts head
- iw_data  out  instruction_t  equals instruction_word
- count  out  [$clog2(DEPTH):0]  occupied entries, 0..DEPTH
- full, empty  out  1  count==DEPTH, count==0

## Operation
- State: wr_ptr, rd_ptr (address_t), count, last_grant ([$clog2(NUM_REQ)]-bit, minimum 1 bit).
- Grant: when !full && !flush && !reset, scan req_valid starting from index last_grant+1 mod NUM_REQ. The first set bit wins.
- Only the winner's req_ready is 1. All req_ready are 0 when no request is pending, when full, or when flush is high.
- req_ready does not depend on iw_ready. When full, a pop in the same cycle does not admit a write.
- Write: load_en = |(req_valid & req_ready). opcode/operand_a/operand_b are muxed from the winner. write_pointer = wr_ptr. The register captures the entry on the same edge.
- On a write: wr_ptr increments; last_grant is set to the winner.
- Pointers wrap from DEPTH-1 to 0 by natural address_t overflow.
- Read: read_pointer = rd_ptr; iw_valid = !empty && !flush; iw_data = instruction_word.
- On a pop (iw_valid && iw_ready), rd_ptr increments.
- count update: count+1 on write only; count-1 on pop only; unchanged on both or neither.
- Writing into an empty queue: iw_valid rises on the next cycle. There is no same-cycle bypass.
- flush: on the next edge, wr_ptr, rd_ptr and count go to 0. Register contents are untouched. Writes and pops are suppressed during the flush cycle. last_grant is kept.
- Reset mid-operation: all state clears immediately; any in-flight handshake is lost.

## Timing
- Outputs while reset is high and after release: req_ready=0, load_en=0, write_pointer=0, read_pointer=0, count=0, empty=1, full=0, iw_valid=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- Request to stored: 0 cycles; the handshake edge writes the register.
- Request to iw_valid (empty queue): 1 cycle.
- Sustained throughput: one write and one pop per cycle.
- Combinational paths: req_valid->req_ready/load_en/data mux; instruction_word->iw_data.
- No path from iw_ready to req_ready.

## Configuration
- INSTR_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins. last_grant is not implemented.
- INSTR_SCHED_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- instr_register_pkg holds opcode_t, operand_t, address_t and instruction_t.
- Add to instr_register_pkg: localparam IR_DEPTH = 32 and typedef count_t.
- One sub-module: rr_arbiter (NUM_REQ, req, last_grant -> one-hot grant, grant index). It contains the fixed-priority variant under the macro.
- The scheduler does not instantiate instr_register; the top level connects the two.

## Test plan
- Reset: assert reset mid-burst with count=5 -> all outputs go to reset values immediately; count=0 and iw_valid=0 after release.
- Round-robin: req_valid=2'b11 held for 4 cycles -> grants 0,1,0,1; write_pointer 0,1,2,3; count=4.
- Fill and wrap: 32 writes from requester 1 with iw_ready=0 -> full=1, req_ready=0 on the 33rd cycle. Then pop 1 and write 1 -> write_pointer=0 and read_pointer=1.
- Simultaneous: count=3, write and pop in the same cycle -> count stays 3. The popped iw_data.opc equals the first opcode written.
- Flush: count=7, flush with req_valid=1 -> no load_en that cycle; next cycle count=0, empty=1, pointers=0.
- Fixed priority (INSTR_SCHED_FIXED_PRIO_EN defined): req_valid=2'b11 for 3 cycles -> requester 0 is granted all 3.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the 32-entry instruction register and its write/read scheduler.
// Config macro used by the scheduler: INSTR_SCHED_FIXED_PRIO_EN.
package instr_register_pkg;

  localparam int IR_DEPTH = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [$clog2(IR_DEPTH)-1:0] address_t;

  // One extra bit so a completely full queue (IR_DEPTH) is representable.
  typedef logic [$clog2(IR_DEPTH):0] count_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  // Ring-order pointer advance; wraps DEPTH-1 -> 0 by natural overflow.
  function automatic address_t ptr_inc(input address_t ptr);
    return ptr + address_t'(1);
  endfunction

endpackage

// File: rtl/instr_reg_scheduler_arbiter.sv
// Write-port arbiter: round-robin after last_grant, or lowest-index-wins when
// INSTR_SCHED_FIXED_PRIO_EN is defined (last_grant is then ignored).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LG_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [LG_W-1:0]    grant_idx,
  output logic               grant_any
);

`ifdef INSTR_SCHED_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Scan downwards so the lowest set index is the final assignment.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = LG_W'(i);
        grant_any = 1'b1;
      end
    end
  end
`else
  // Offsets NUM_REQ..1 after last_grant, descending, so offset 1 wins ties.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_REQ]) begin
        grant_idx = LG_W'((int'(last_grant) + k) % NUM_REQ);
        grant_any = 1'b1;
      end
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_idx == LG_W'(gi));
  end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Shares the instruction register's write port among NUM_REQ requesters and walks
// read_pointer in ring order, making the register a DEPTH-deep queue.
// Config macro: INSTR_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = IR_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  opcode_t                req_opcode    [NUM_REQ],
  input  operand_t               req_operand_a [NUM_REQ],
  input  operand_t               req_operand_b [NUM_REQ],
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   flush,
  output logic                   load_en,
  output address_t               write_pointer,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               read_pointer,
  input  instruction_t           instruction_word,
  output logic                   iw_valid,
  input  logic                   iw_ready,
  output instruction_t           iw_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int     LG_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam count_t FULL_COUNT = count_t'(DEPTH);

  address_t        wr_ptr_reg, wr_ptr_next;
  address_t        rd_ptr_reg, rd_ptr_next;
  count_t          count_reg,  count_next;
  logic [LG_W-1:0] last_grant;
  logic [LG_W-1:0] grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic            grant_any;
  logic            allow;
  logic            write_en;
  logic            pop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Admission ignores iw_ready on purpose: a pop never frees a slot in the same cycle.
  assign allow = !full && !flush && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LG_W    (LG_W)
  ) u_arbiter (
    .req        (req_valid & {NUM_REQ{allow}}),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign req_ready     = grant;
  assign write_en      = |(req_valid & req_ready);
  assign load_en       = write_en;
  assign write_pointer = wr_ptr_reg;

  always_comb begin
    opcode    = req_opcode[0];
    operand_a = req_operand_a[0];
    operand_b = req_operand_b[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        opcode    = req_opcode[i];
        operand_a = req_operand_a[i];
        operand_b = req_operand_b[i];
      end
    end
  end

  assign read_pointer = rd_ptr_reg;
  assign iw_valid     = !empty && !flush;
  assign iw_data      = instruction_word;
  assign pop          = iw_valid && iw_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (write_en) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)      rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({write_en, pop})
        2'b10:   count_next = count_reg + count_t'(1);
        2'b01:   count_next = count_reg - count_t'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

`ifdef INSTR_SCHED_FIXED_PRIO_EN
  logic unused_grant_idx;
  assign last_grant       = '0;
  assign unused_grant_idx = ^grant_idx;
`else
  logic [LG_W-1:0] last_grant_reg;

  // Reset to NUM_REQ-1 so requester 0 gets first priority; kept across flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= LG_W'(NUM_REQ - 1);
    end else if (write_en) begin
      last_grant_reg <= grant_idx;
    end
  end

  assign last_grant = last_grant_reg;
`endif

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed, table-driven bench for instr_reg_scheduler with a behavioural register model.
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  opcode_t      req_opcode    [2];
  operand_t     req_operand_a [2];
  operand_t     req_operand_b [2];
  logic [1:0]   req_ready;
  logic         flush;
  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         iw_valid;
  logic         iw_ready;
  instruction_t iw_data;
  logic [5:0]   count;
  logic         full;
  logic         empty;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  instr_reg_scheduler #(.NUM_REQ(2), .DEPTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_opcode       (req_opcode),
    .req_operand_a    (req_operand_a),
    .req_operand_b    (req_operand_b),
    .req_ready        (req_ready),
    .flush            (flush),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .iw_valid         (iw_valid),
    .iw_ready         (iw_ready),
    .iw_data          (iw_data),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  // Behavioural instruction register: write on edge, combinational read.
  instruction_t mem [32];
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  end
  assign instruction_word = mem[read_pointer];

  typedef struct {
    logic [1:0]  valid;
    logic        rdy;
    logic        fl;
    logic [1:0]  exp_ready;
    logic        exp_load;
    logic [4:0]  exp_wp;
    logic [4:0]  exp_rp;
    logic [5:0]  exp_count;
    logic        exp_iwv;
    logic [2:0]  exp_opc;
    logic [31:0] exp_opa;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_data(input int seed);
    for (int i = 0; i < 2; i++) begin
      req_opcode[i]    = opcode_t'((seed * 2 + i) % 8);
      req_operand_a[i] = operand_t'(seed * 16 + i);
      req_operand_b[i] = ~operand_t'(seed * 16 + i);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //           valid  rdy  fl    ready  ld   wp  rp  cnt  iwv  opc  opa
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 0, 0, 0, 1'b0, 0, 0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 1, 0, 1, 1'b1, 0, 0};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 2, 0, 2, 1'b1, 0, 0};
    vecs[3]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 3, 0, 3, 1'b1, 0, 0};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 4, 0, 4, 1'b1, 0, 0};
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4, 0, 4, 1'b1, 0, 0};
    vecs[6]  = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 5, 1, 4, 1'b1, 3, 17};
    vecs[7]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 6, 2, 4, 1'b1, 4, 32};
    vecs[8]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 6, 3, 3, 1'b0, 0, 0};
    vecs[9]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0, 0, 0};
    vecs[10] = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 0, 0, 0, 1'b0, 0, 0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1, 0, 1, 1'b1, 4, 160};

    reset     = 1'b1;
    req_valid = 2'b11;
    iw_ready  = 1'b0;
    flush     = 1'b0;
    drive_data(0);

    // Reset state, with requests pending while reset is high.
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_load", 64'(load_en), 64'(0));
    chk("rst_wp", 64'(write_pointer), 64'(0));
    chk("rst_rp", 64'(read_pointer), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_iwv", 64'(iw_valid), 64'(0));
    reset     = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("rel_count", 64'(count), 64'(0));
    chk("rel_iwv", 64'(iw_valid), 64'(0));
    next_cycle();

    // Round-robin, simultaneous write+pop, flush and post-flush priority.
    for (int i = 0; i < 12; i++) begin
      req_valid = vecs[i].valid;
      iw_ready  = vecs[i].rdy;
      flush     = vecs[i].fl;
      drive_data(i);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d_load", i), 64'(load_en), 64'(vecs[i].exp_load));
      chk($sformatf("v%0d_wp", i), 64'(write_pointer), 64'(vecs[i].exp_wp));
      chk($sformatf("v%0d_rp", i), 64'(read_pointer), 64'(vecs[i].exp_rp));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      chk($sformatf("v%0d_iwv", i), 64'(iw_valid), 64'(vecs[i].exp_iwv));
      if (vecs[i].exp_iwv) begin
        chk($sformatf("v%0d_opc", i), 64'(iw_data.opc), 64'(vecs[i].exp_opc));
        chk($sformatf("v%0d_opa", i), 64'(iw_data.op_a), 64'(vecs[i].exp_opa));
      end
      if (vecs[i].exp_load) begin
        chk($sformatf("v%0d_mux_opc", i), 64'(opcode),
            64'((i * 2 + (vecs[i].exp_ready[1] ? 1 : 0)) % 8));
      end
      $display("vec %0d: valid=%b ready=%b wp=%0d rp=%0d count=%0d iw_valid=%b",
               i, req_valid, req_ready, write_pointer, read_pointer, count, iw_valid);
      next_cycle();
    end
    flush    = 1'b0;
    iw_ready = 1'b0;

    // Reset asserted mid-burst at count=5.
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      drive_data(50 + k);
      next_cycle();
    end
    chk("burst_count", 64'(count), 64'(5));
    req_valid = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(2'b00));
    chk("midrst_load", 64'(load_en), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_wp", 64'(write_pointer), 64'(0));
    chk("midrst_empty", 64'(empty), 64'(1));
    chk("midrst_iwv", 64'(iw_valid), 64'(0));
    $display("mid-burst reset: count=%0d ready=%b", count, req_ready);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    next_cycle();
    chk("postrst_count", 64'(count), 64'(0));
    chk("postrst_iwv", 64'(iw_valid), 64'(0));

    // Fill all 32 entries from requester 1, then wrap.
    req_valid = 2'b10;
    for (int k = 0; k < 32; k++) begin
      drive_data(200 + k);
      #1;
      chk($sformatf("fill%0d_ready", k), 64'(req_ready), 64'(2'b10));
      chk($sformatf("fill%0d_wp", k), 64'(write_pointer), 64'(k));
      $display("fill %0d: wp=%0d count=%0d", k, write_pointer, count);
      next_cycle();
    end
    drive_data(300);
    #1;
    chk("full_flag", 64'(full), 64'(1));
    chk("full_ready", 64'(req_ready), 64'(2'b00));
    chk("full_load", 64'(load_en), 64'(0));
    chk("full_count", 64'(count), 64'(32));
    next_cycle();
    iw_ready = 1'b1;
    #1;
    chk("fullpop_ready", 64'(req_ready), 64'(2'b00));
    chk("fullpop_iwv", 64'(iw_valid), 64'(1));
    chk("fullpop_opc", 64'(iw_data.opc), 64'(1));
    chk("fullpop_opa", 64'(iw_data.op_a), 64'(3201));
    $display("pop while full: opc=%0d op_a=%0d", iw_data.opc, iw_data.op_a);
    next_cycle();
    iw_ready = 1'b0;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'(2'b10));
    chk("wrap_wp", 64'(write_pointer), 64'(0));
    chk("wrap_rp", 64'(read_pointer), 64'(1));
    chk("wrap_count", 64'(count), 64'(31));
    $display("wrap write: wp=%0d rp=%0d count=%0d", write_pointer, read_pointer, count);
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("refull_count", 64'(count), 64'(32));
    chk("refull_flag", 64'(full), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
